// File: rtl/msrv32_imm_gen_stage_pkg.sv
// -----------------------------------------------------------------------------
// msrv32_imm_pkg
// Shared definitions for the msrv32 immediate-generation stage.
//   - IMM_* : imm_type encodings driven by the decode/control unit.
//   - imm_entry_t : one buffer entry (valid, misalign flag, immediate, tag).
//     The immediate and tag fields are sized for the widest legal build
//     (XLEN=64, TAG_W<=16); narrower builds zero-pad the upper bits.
// Optional feature macro used by the stage: MSRV32_IMM_MISALIGN_CHK_EN.
// -----------------------------------------------------------------------------
package msrv32_imm_pkg;

  localparam logic [2:0] IMM_I0  = 3'b000;
  localparam logic [2:0] IMM_I1  = 3'b001;
  localparam logic [2:0] IMM_S   = 3'b010;
  localparam logic [2:0] IMM_B   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_J   = 3'b101;
  localparam logic [2:0] IMM_CSR = 3'b110;
  localparam logic [2:0] IMM_I2  = 3'b111;

  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 misalign;
    logic [IMM_MAX_W-1:0] imm;
    logic [TAG_MAX_W-1:0] tag;
  } imm_entry_t;

endpackage

// File: rtl/msrv32_imm_gen_stage_if.sv
// -----------------------------------------------------------------------------
// msrv32_imm_gen_stage_if
// Handshake bundle of the immediate-generation stage.
//   Input side : in_valid_in, in_ready_out, instr_in[31:0], imm_type_in[2:0],
//                tag_in[TAG_W-1:0]
//   Output side: out_valid_out, out_ready_in, imm_out[XLEN-1:0],
//                tag_out[TAG_W-1:0], misalign_out (only with
//                MSRV32_IMM_MISALIGN_CHK_EN defined)
// Modports: slave  = the stage itself
//           master = the surrounding pipeline (upstream + downstream)
// -----------------------------------------------------------------------------
interface msrv32_imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             in_valid_in;
  logic             in_ready_out;
  logic [31:0]      instr_in;
  logic [2:0]       imm_type_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid_out;
  logic             out_ready_in;
  logic [XLEN-1:0]  imm_out;
  logic [TAG_W-1:0] tag_out;
`ifdef MSRV32_IMM_MISALIGN_CHK_EN
  logic             misalign_out;
`endif

  modport slave (
    input  in_valid_in, instr_in, imm_type_in, tag_in, out_ready_in,
    output in_ready_out, out_valid_out, imm_out, tag_out
`ifdef MSRV32_IMM_MISALIGN_CHK_EN
    , output misalign_out
`endif
  );

  modport master (
    output in_valid_in, instr_in, imm_type_in, tag_in, out_ready_in,
    input  in_ready_out, out_valid_out, imm_out, tag_out
`ifdef MSRV32_IMM_MISALIGN_CHK_EN
    , input misalign_out
`endif
  );
endinterface

// File: rtl/msrv32_imm_gen_stage_decode.sv
// -----------------------------------------------------------------------------
// msrv32_imm_decode
// Purely combinational RV32I immediate decoder, output width XLEN (32 or 64).
//   i_instr[31:0]   raw instruction word
//   i_imm_type[2:0] immediate format (see msrv32_imm_pkg IMM_*)
//   o_imm[XLEN-1:0] decoded immediate; signed formats take their sign from
//                   instr[31], CSR zimm is zero-extended
// -----------------------------------------------------------------------------
module msrv32_imm_decode
  import msrv32_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  input  logic [2:0]      i_imm_type,
  output logic [XLEN-1:0] o_imm
);

  logic signed [31:0] w_imm32;
  logic               w_unused_opcode;

  // The opcode field never contributes to an immediate.
  assign w_unused_opcode = &{1'b0, i_instr[6:0]};

  always_comb begin
    w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
    case (i_imm_type)
      IMM_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B:   w_imm32 = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                          i_instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {i_instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                          i_instr[30:21], 1'b0};
      IMM_CSR: w_imm32 = {27'b0, i_instr[19:15]};
      default: w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
    endcase
  end

  // Signed cast: widening to 64 bits replicates bit 31. CSR values are
  // positive here, so the same path zero-extends them.
  assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/msrv32_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// msrv32_imm_gen_stage
// Registered immediate-generation stage between decode and the ALU operand
// mux. Decode happens on the input side; an output register (OUT) backed by a
// skid register (SKID) holds finished immediates, giving full throughput under
// backpressure with in_ready_out taken straight from a flop.
//   clk_in   core clock (rising edge)
//   rst_in   synchronous active-high reset
//   flush_in synchronous drop of both buffered entries (and any same-cycle
//            acceptance)
//   bus      msrv32_imm_gen_stage_if.slave handshake bundle
// Optional: define MSRV32_IMM_MISALIGN_CHK_EN to add bus.misalign_out, set for
// B/J immediates whose bit 1 is set, carried with its entry.
// Parameters: XLEN (32 or 64), TAG_W (1..16).
// -----------------------------------------------------------------------------
module msrv32_imm_gen_stage
  import msrv32_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  flush_in,
  msrv32_imm_gen_stage_if.slave bus
);

  logic [XLEN-1:0] w_imm;
  imm_entry_t      w_new;
  imm_entry_t      r_out;
  imm_entry_t      r_skid;
  logic            w_acc;
  logic            w_drain;
  logic            w_unused_pad;

  msrv32_imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr    (bus.instr_in),
    .i_imm_type (bus.imm_type_in),
    .o_imm      (w_imm)
  );

  always_comb begin
    w_new          = '0;
    w_new.valid    = 1'b1;
    w_new.imm      = IMM_MAX_W'(w_imm);
    w_new.tag      = TAG_MAX_W'(bus.tag_in);
`ifdef MSRV32_IMM_MISALIGN_CHK_EN
    w_new.misalign = ((bus.imm_type_in == IMM_B) || (bus.imm_type_in == IMM_J))
                     && w_imm[1];
`endif
  end

  assign w_acc   = bus.in_valid_in & ~r_skid.valid;
  assign w_drain = r_out.valid & bus.out_ready_in;

  // Stage boundary: OUT/SKID registers. SKID only fills while OUT is stalled,
  // and OUT refills from SKID before taking new input, which keeps order FIFO.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_out        <= '0;
      r_skid.valid <= 1'b0;
    end else if (flush_in) begin
      r_out.valid  <= 1'b0;
      r_skid.valid <= 1'b0;
    end else if (!r_out.valid || w_drain) begin
      if (r_skid.valid) begin
        r_out        <= r_skid;
        r_skid.valid <= 1'b0;
      end else if (w_acc) begin
        r_out <= w_new;
      end else begin
        r_out.valid <= 1'b0;
      end
    end else if (w_acc) begin
      r_skid <= w_new;
    end
  end

  assign bus.in_ready_out  = ~r_skid.valid;
  assign bus.out_valid_out = r_out.valid;
  assign bus.imm_out       = r_out.imm[XLEN-1:0];
  assign bus.tag_out       = r_out.tag[TAG_W-1:0];
`ifdef MSRV32_IMM_MISALIGN_CHK_EN
  assign bus.misalign_out  = r_out.misalign;
`endif

  // Padding bits above XLEN/TAG_W (and the flag when the check is off) are
  // constant and deliberately left unread.
  assign w_unused_pad = ^{r_out, r_skid};

endmodule
